tqvp_rs_syndrome_engine: RTL
============================

// Module: tqvp_rs_syndrome_engine
// PURPOSE
//  Parametrised streaming Reed-Solomon syndrome engine on the TinyQV peripheral bus; successor to the
//  fixed GF(256) pipeline front end. Field width, syndrome count, field polynomial, generator and
//  first-consecutive-root are programmable. Host streams symbols (highest degree first) and reads
//  back packed syndromes. Feeds the downstream Berlekamp-Massey stage.
// PARAMETERS
//  M         8      symbol width in bits (GF(2^M)), legal 3..8
//  NSYN      32     syndromes computed (2t), multiple of 4, legal 4..32
//  POLY_RST  9'h11D reset value of field polynomial (M+1 bits used)
// PORTS
//  clk            in   1   peripheral clock (64 MHz)
//  rst_n          in   1   asynchronous active-low reset
//  ui_in          in   8   unused
//  uo_out         out  8   status pins (see CONFIGURATION)
//  address        in   6   byte address within peripheral
//  data_in        in   32  write data
//  data_write_n   in   2   11 none, 00 8b, 01 16b, 10 32b
//  data_read_n    in   2   11 none, 00 8b, 01 16b, 10 32b
//  data_out       out  32  read data, valid while data_ready=1
//  data_ready     out  1   read acknowledge
//  user_interrupt out  1   level IRQ, done & IRQ_EN
// BEHAVIOUR
//  Registers (word addr): 0x00 CTRL W {b2 CLR, b1 IRQ_EN, b0 START}; 0x04 STATUS R {[15:8] symcnt,
//   b3 OVERRUN, b2 NONZERO, b1 DONE, b0 BUSY}; 0x08 POLY RW [M:0]; 0x0C GEN RW [M-1:0];
//   0x10 FCR RW [7:0]; 0x14 BLEN RW [7:0] (N); 0x18 DATA W; 0x20+4k SYN R, k<NSYN/4,
//   bytes = S[4k]..S[4k+3] low first (upper M..7 bits zero). Unmapped reads return 0.
//  Reset: all outputs 0; state IDLE; flags/counters/S[]/roots 0; POLY=POLY_RST, GEN=2, FCR=0, BLEN=255.
//  Reads: data_ready=1 the cycle after data_read_n!=11 (registered data_out), for one cycle.
//  FSM IDLE -> ROOTGEN on START (also from any state: abort+restart). START clears S[], symcnt,
//   DONE, NONZERO, OVERRUN, staging buffer.
//  ROOTGEN: r=GEN^FCR by FCR serial GF mults (r=1 if FCR=0), then root[i]=root[i-1]*GEN,
//   one per cycle; exactly FCR+NSYN cycles, then RUN. BUSY=1 in ROOTGEN and RUN.
//  DATA write: pushes 1/2/4 symbols (8/16/32b), bytes low first, masked to M bits, into a 4-entry
//   staging FIFO. Accepted in ROOTGEN or RUN only if all fit; else entire write dropped, OVERRUN=1.
//   Writes in IDLE/DONE dropped, OVERRUN=1.
//  RUN: pops one symbol/cycle; all i in parallel S[i] <= S[i]*root[i] ^ sym; symcnt++.
//   Symbols staged beyond N discarded, OVERRUN=1.
//  symcnt==N -> DONE next cycle: BUSY=0, DONE=1, NONZERO=|S[]. N=0: DONE directly after ROOTGEN.
//  Configuration writes while BUSY take effect at next START only (shadowed at START).
//  GF multiply: shift-and-add, reduce by POLY each step, combinational, single cycle.
//  CLR: clears DONE and OVERRUN (IRQ drops next cycle); START+CLR same write: START wins.
//  rst_n low mid-operation: immediate return to reset state, in-flight symbols lost.
// CONFIGURATION
//  TQVP_RS_UO_STATUS_EN defined: uo_out = {4'b0, OVERRUN, NONZERO, DONE, BUSY}, registered.
//  Not defined: uo_out = 8'h00 constantly; register map unchanged.
// TESTING (M=8, NSYN=32, POLY=0x11D, GEN=2, FCR=0 unless stated)
//  1 BLEN=255, START, 255 zero symbols -> DONE after 32+255(+1) cycles, all SYN=0, NONZERO=0.
//  2 BLEN=2, START, DATA 16b 0x0001 (sym 01 then 00) -> S[0..3]=01,02,04,08; SYN0 read=0x08040201.
//  3 BLEN=1, FCR=1, START, DATA 8b 0x05 -> all S=05, NONZERO=1, IRQ only if IRQ_EN.
//  4 DATA write in IDLE, and 32b write with 1 free FIFO slot -> OVERRUN=1, symcnt unchanged.
//  5 BLEN=3, 32b DATA 0x04030201 -> symcnt=3, symbol 04 discarded, OVERRUN=1, DONE=1.
//  6 rst_n low mid-RUN -> STATUS=0, SYN all 0, POLY=0x11D, user_interrupt=0.

Source files
------------

// File: rtl/tqvp_rs_syndrome_engine_if.sv
// TinyQV peripheral bus bundle for the RS syndrome engine.
// master = host side, slave = peripheral side.
interface tqvp_rs_syndrome_engine_if;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;

  modport master (
    output address, data_in, data_write_n, data_read_n,
    input  data_out, data_ready, user_interrupt
  );

  modport slave (
    input  address, data_in, data_write_n, data_read_n,
    output data_out, data_ready, user_interrupt
  );
endinterface

// File: rtl/tqvp_rs_syndrome_engine.sv
// Streaming Reed-Solomon syndrome engine, GF(2^M), NSYN syndromes.
// Roots are generated serially at START, then each staged symbol
// updates all syndrome lanes in parallel (Horner evaluation).
// Optional: TQVP_RS_UO_STATUS_EN drives status flags onto uo_out.

// GF(2^M) multiply, shift-and-add with reduction every step.
module tqvp_rs_gf_mul #(parameter int M = 8) (
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  input  logic [M-1:0] red,   // field polynomial without its x^M term
  output logic [M-1:0] p
);
  logic [M-1:0] aa;
  // accumulate a*x^i for each set bit of b, keeping a*x^i reduced
  always_comb begin
    p  = '0;
    aa = a;
    for (int i = 0; i < M; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[M-1] ? ((aa << 1) ^ red) : (aa << 1);
    end
  end
endmodule

// One syndrome accumulator: S <= S*root ^ sym per accepted symbol.
module tqvp_rs_syn_lane #(parameter int M = 8) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [M-1:0] sym,
  input  logic [M-1:0] root,
  input  logic [M-1:0] red,
  output logic [M-1:0] s
);
  logic [M-1:0] prod;

  tqvp_rs_gf_mul #(.M(M)) u_mul (.a(s), .b(root), .red(red), .p(prod));

  // START wipes the accumulator ahead of any same-cycle symbol
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)   s <= '0;
    else if (clr) s <= '0;
    else if (en)  s <= prod ^ sym;
endmodule

module tqvp_rs_syndrome_engine #(
  parameter int         M        = 8,
  parameter int         NSYN     = 32,
  parameter logic [8:0] POLY_RST = 9'h11D
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  tqvp_rs_syndrome_engine_if.slave bus
);
  localparam int NW = NSYN / 4;

  typedef enum logic [1:0] {IDLE, ROOTGEN, RUN, DONE_S} state_t;
  state_t state;

  logic [M:0]   poly_r;
  logic [M-1:0] gen_r, red_s, gen_s, r_acc, r_next;
  logic [7:0]   fcr_r, blen_r, fcr_s, blen_s, symcnt;
  logic         irq_en, done, nonzero, overrun;
  logic [8:0]   rg_cnt, rg_last, rg_idx;
  logic [NSYN-1:0][M-1:0] root, s_all;
  logic [3:0][M-1:0] fifo;
  logic [3:0][1:0]   wr_idx;
  logic [1:0]   f_rd;
  logic [2:0]   f_cnt, n_push;
  logic [3:0]   push_m;
  logic [31:0]  rdata;

  logic [3:0] wa;
  logic wr, rd, ctrl_wr, start, clr, data_wr, busy, fin, push_ok, pop;

  assign wa      = bus.address[5:2];
  assign wr      = bus.data_write_n != 2'b11;
  assign rd      = bus.data_read_n  != 2'b11;
  assign ctrl_wr = wr && wa == 4'h0;
  assign start   = ctrl_wr && bus.data_in[0];
  assign clr     = ctrl_wr && bus.data_in[2] && !bus.data_in[0];
  assign data_wr = wr && wa == 4'h6;
  assign busy    = state == ROOTGEN || state == RUN;
  assign fin     = state == RUN && symcnt == blen_s;
  assign push_ok = data_wr && busy && !fin &&
                   ({1'b0, f_cnt} + {1'b0, n_push}) <= 4'd4;
  assign pop     = state == RUN && !fin && f_cnt != 3'd0;
  assign rg_last = 9'(fcr_s) + 9'(NSYN - 1);
  assign rg_idx  = rg_cnt - 9'(fcr_s);
  assign bus.user_interrupt = done & irq_en;

  logic unused_ok;
  assign unused_ok = &{1'b0, ui_in, bus.address[1:0]};

  // symbols per DATA write and the FIFO slots they land in
  always_comb begin
    case (bus.data_write_n)
      2'b00:   begin n_push = 3'd1; push_m = 4'b0001; end
      2'b01:   begin n_push = 3'd2; push_m = 4'b0011; end
      default: begin n_push = 3'd4; push_m = 4'b1111; end
    endcase
    for (int j = 0; j < 4; j++) wr_idx[j] = f_rd + f_cnt[1:0] + 2'(j);
  end

  tqvp_rs_gf_mul #(.M(M)) u_rmul (.a(r_acc), .b(gen_s), .red(red_s), .p(r_next));

  for (genvar i = 0; i < NSYN; i++) begin : g_lane
    tqvp_rs_syn_lane #(.M(M)) u_lane (
      .clk, .rst_n, .clr(start), .en(pop), .sym(fifo[f_rd]),
      .root(root[i]), .red(red_s), .s(s_all[i])
    );
  end

  // root table: root[i] = GEN^(FCR+i), one entry per ROOTGEN cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) root <= '0;
    else if (state == ROOTGEN && rg_cnt >= 9'(fcr_s))
      for (int i = 0; i < NSYN; i++)
        if (rg_idx == 9'(i)) root[i] <= r_acc;

  // staging FIFO storage
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) fifo <= '0;
    else if (push_ok)
      for (int j = 0; j < 4; j++)
        if (push_m[j]) fifo[wr_idx[j]] <= bus.data_in[8*j +: M];

  // control FSM, config registers, flags and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      poly_r  <= POLY_RST[M:0];
      gen_r   <= M'(2);
      fcr_r   <= '0;
      blen_r  <= 8'd255;
      red_s   <= POLY_RST[M-1:0];
      gen_s   <= M'(2);
      fcr_s   <= '0;
      blen_s  <= 8'd255;
      irq_en  <= 1'b0;
      done    <= 1'b0;
      nonzero <= 1'b0;
      overrun <= 1'b0;
      symcnt  <= '0;
      rg_cnt  <= '0;
      r_acc   <= '0;
      f_rd    <= '0;
      f_cnt   <= '0;
    end else begin
      if (wr && wa == 4'h2) poly_r <= bus.data_in[M:0];
      if (wr && wa == 4'h3) gen_r  <= bus.data_in[M-1:0];
      if (wr && wa == 4'h4) fcr_r  <= bus.data_in[7:0];
      if (wr && wa == 4'h5) blen_r <= bus.data_in[7:0];
      if (ctrl_wr) irq_en <= bus.data_in[1];
      if (data_wr && !push_ok) overrun <= 1'b1;

      f_cnt <= f_cnt + (push_ok ? n_push : 3'd0) - 3'(pop);
      if (pop) begin
        f_rd   <= f_rd + 2'd1;
        symcnt <= symcnt + 8'd1;
      end

      case (state)
        ROOTGEN: begin
          r_acc  <= r_next;
          rg_cnt <= rg_cnt + 9'd1;
          if (rg_cnt == rg_last) begin
            if (blen_s == 8'd0) begin
              state <= DONE_S;
              done  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: if (fin) begin
          state   <= DONE_S;
          done    <= 1'b1;
          nonzero <= |s_all;
          if (f_cnt != 3'd0) overrun <= 1'b1;  // leftovers past N are dropped
          f_cnt   <= '0;
        end
        default: ;
      endcase

      if (clr) begin
        done    <= 1'b0;
        overrun <= 1'b0;
        if (state == DONE_S) state <= IDLE;
      end

      // START from any state aborts and restarts with a fresh config snapshot
      if (start) begin
        state   <= ROOTGEN;
        red_s   <= poly_r[M-1:0];
        gen_s   <= gen_r;
        fcr_s   <= fcr_r;
        blen_s  <= blen_r;
        done    <= 1'b0;
        nonzero <= 1'b0;
        overrun <= 1'b0;
        symcnt  <= '0;
        rg_cnt  <= '0;
        r_acc   <= M'(1);
        f_rd    <= '0;
        f_cnt   <= '0;
      end
    end
  end

  // register read mux; unmapped and write-only addresses read 0
  always_comb begin
    rdata = '0;
    case (wa)
      4'h1: rdata = {16'h0, symcnt, 4'h0, overrun, nonzero, done, busy};
      4'h2: rdata = 32'(poly_r);
      4'h3: rdata = 32'(gen_r);
      4'h4: rdata = {24'h0, fcr_r};
      4'h5: rdata = {24'h0, blen_r};
      default:
        if (wa[3])
          for (int k = 0; k < NW; k++)
            if (wa[2:0] == 3'(k))
              for (int b = 0; b < 4; b++) rdata[8*b +: 8] = 8'(s_all[4*k+b]);
    endcase
  end

  // one-cycle read acknowledge with registered data
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.data_ready <= 1'b0;
      bus.data_out   <= '0;
    end else begin
      bus.data_ready <= rd && !bus.data_ready;
      bus.data_out   <= (rd && !bus.data_ready) ? rdata : 32'h0;
    end

`ifdef TQVP_RS_UO_STATUS_EN
  // status flags mirrored onto the pins
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) uo_out <= '0;
    else        uo_out <= {4'b0, overrun, nonzero, done, busy};
`else
  assign uo_out = 8'h00;
`endif
endmodule
